// File: rtl/handshake_rr_merge.sv
// ---------------------------------------------------------------------------
// handshake_rr_merge
//
// Purpose:
//   Fair round-robin fan-in of NUM_CHANNEL valid/ready beat streams onto a
//   single registered output stream. Each output beat is tagged with the
//   channel it came from. Once a channel starts a multi-beat packet, the
//   grant stays with that channel until its last beat has been accepted.
//   The output register is refilled in the same cycle it drains, so the
//   merge sustains one beat per clock.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   rst       in   asynchronous, active-high reset
//   rx_valid  in   [NUM_CHANNEL]             per-channel beat valid
//   rx_ready  out  [NUM_CHANNEL]             per-channel accept (one-hot or zero)
//   rx_data   in   [NUM_CHANNEL*DATA_WIDTH]  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rx_last   in   [NUM_CHANNEL]             final beat of a packet
//   tx_valid  out  registered output beat valid
//   tx_ready  in   downstream accept
//   tx_data   out  [DATA_WIDTH] registered payload
//   tx_last   out  registered packet-end flag
//   tx_chan   out  [CHAN_W] registered source channel index
//   o_busy    out  high while a multi-beat packet holds the grant
// ---------------------------------------------------------------------------
module handshake_rr_merge #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_CHANNEL = 2,
    localparam int CHAN_W      = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CHANNEL-1:0]            rx_valid,
    output logic [NUM_CHANNEL-1:0]            rx_ready,
    input  logic [NUM_CHANNEL*DATA_WIDTH-1:0] rx_data,
    input  logic [NUM_CHANNEL-1:0]            rx_last,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [DATA_WIDTH-1:0]             tx_data,
    output logic                              tx_last,
    output logic [CHAN_W-1:0]                 tx_chan,
    output logic                              o_busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [CHAN_W-1:0]   rr_ptr, rr_ptr_d;
    logic [CHAN_W-1:0]   lock_chan, lock_chan_d;

    logic                can_load;
    logic                grant_valid;
    logic [CHAN_W-1:0]   grant_idx;
    logic                sel_ok;
    logic [CHAN_W-1:0]   sel_chan;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                xfer;

    // Channel index 'offset' steps after 'base', wrapping at NUM_CHANNEL.
    // Works for non-power-of-two channel counts.
    function automatic int rr_index(input logic [CHAN_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CHANNEL) begin
            sum = sum - NUM_CHANNEL;
        end
        return sum;
    endfunction

    function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] chan);
        logic [CHAN_W-1:0] nxt;
        if (chan == CHAN_W'(NUM_CHANNEL - 1)) begin
            nxt = '0;
        end else begin
            nxt = chan + 1'b1;
        end
        return nxt;
    endfunction

    // The output slot can take a new beat when empty or draining this cycle.
    assign can_load = !tx_valid || tx_ready;
    assign o_busy   = (state == LOCKED);

    // Round-robin search: first valid channel starting at rr_ptr.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no value is remembered between evaluations and no
    // latch is inferred; clocked blocks use '<=' only.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CHANNEL; k++) begin
            idx = rr_index(rr_ptr, k);
            if (!grant_valid && rx_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CHAN_W'(idx);
            end
        end
    end

    // Selected channel: the locked one while a packet is open, otherwise the
    // round-robin winner. In LOCKED the ready does not wait for valid.
    always_comb begin
        sel_ok    = (state == LOCKED) ? 1'b1 : grant_valid;
        sel_chan  = (state == LOCKED) ? lock_chan : grant_idx;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        rx_ready  = '0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            if (sel_chan == CHAN_W'(i)) begin
                sel_valid   = rx_valid[i];
                sel_last    = rx_last[i];
                sel_data    = rx_data[i*DATA_WIDTH +: DATA_WIDTH];
                rx_ready[i] = sel_ok && can_load;
            end
        end
        xfer = sel_ok && can_load && sel_valid;
    end

    // Next-state: a last beat releases the grant and moves the pointer past
    // the finishing channel; a non-last beat locks onto its channel.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        lock_chan_d = lock_chan;
        if (xfer) begin
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = next_chan(sel_chan);
            end else begin
                state_d     = LOCKED;
                lock_chan_d = sel_chan;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock_chan <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            lock_chan <= lock_chan_d;
        end
    end

    // Output slot: a load wins over a drain, so a beat leaving and a beat
    // arriving in the same cycle keeps tx_valid high with the new payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            tx_chan  <= '0;
        end else if (xfer) begin
            tx_valid <= 1'b1;
            tx_data  <= sel_data;
            tx_last  <= sel_last;
            tx_chan  <= sel_chan;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_handshake_rr_merge.sv
// ---------------------------------------------------------------------------
// tb_handshake_rr_merge
//
// Directed scenarios (reset, single beat, fairness, packet lock,
// backpressure) followed by a randomized phase on channels 0..2. Expected
// beats are queued per channel as stimulus is created; a forked monitor pops
// and compares on each output handshake and tracks the round-robin pointer
// from the arbitration rules to predict every grant.
// ---------------------------------------------------------------------------
module tb_handshake_rr_merge;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      rx_valid;
    logic [NCH-1:0]      rx_ready;
    logic [NCH*DW-1:0]   rx_data;
    logic [NCH-1:0]      rx_last;
    logic                tx_valid;
    logic                tx_ready;
    logic [DW-1:0]       tx_data;
    logic                tx_last;
    logic [CW-1:0]       tx_chan;
    logic                o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_on  = 1'b0;

    beat_t          exp_q [NCH][$];
    int             model_ptr;
    bit             model_locked;
    int             model_lock;
    bit             out_in_pkt;
    int             out_pkt_chan;
    logic [NCH-1:0] xfer_prev;
    logic [NCH-1:0] in_pkt;

    handshake_rr_merge #(
        .DATA_WIDTH (DW),
        .NUM_CHANNEL(NCH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data (rx_data),
        .rx_last (rx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_chan (tx_chan),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
        rx_valid[ch]           = v;
        rx_data[ch*DW +: DW]   = d;
        rx_last[ch]            = l;
    endtask

    // Monitor: output-side scoreboard plus input-side grant prediction.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            #2;
            if (rand_on) begin
                logic [NCH-1:0] xv;
                beat_t          e;
                int             c;
                int             exp_c;
                int             idx;
                bit             found;
                if (tx_valid && tx_ready) begin
                    check("tx_has_expected_beat", 64'(exp_q[tx_chan].size() != 0), 64'd1);
                    if (exp_q[tx_chan].size() != 0) begin
                        e = exp_q[tx_chan].pop_front();
                        check("tx_data", 64'(tx_data), 64'(e.data));
                        check("tx_last", 64'(tx_last), 64'(e.last));
                    end
                    if (out_in_pkt) begin
                        check("tx_contiguous", 64'(tx_chan), 64'(out_pkt_chan));
                    end
                    out_in_pkt   = !tx_last;
                    out_pkt_chan = int'(tx_chan);
                end
                check("rx_ready_onehot0", 64'($onehot0(rx_ready)), 64'd1);
                xv = rx_valid & rx_ready;
                if (xv != '0) begin
                    c = 0;
                    for (int i = 0; i < NCH; i++) begin
                        if (xv[i]) c = i;
                    end
                    exp_c = 0;
                    if (model_locked) begin
                        exp_c = model_lock;
                    end else begin
                        found = 1'b0;
                        for (int k = 0; k < NCH; k++) begin
                            idx = (model_ptr + k) % NCH;
                            if (!found && rx_valid[idx]) begin
                                found = 1'b1;
                                exp_c = idx;
                            end
                        end
                    end
                    check("rr_grant", 64'(c), 64'(exp_c));
                    if (rx_last[c]) begin
                        model_locked = 1'b0;
                        model_ptr    = (c + 1) % NCH;
                    end else begin
                        model_locked = 1'b1;
                        model_lock   = c;
                    end
                end
            end
        end
    endtask

    // One randomized stimulus cycle on channels 0..2. With gen=0 only open
    // packets are closed, so nothing is left stranded behind a lock.
    task automatic drive_cycle(input bit gen);
        logic [DW-1:0] d;
        logic          l;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (xfer_prev[i]) rx_valid[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (!rx_valid[i] && (gen ? ($urandom_range(0, 3) != 0) : in_pkt[i])) begin
                d = $urandom;
                l = gen ? ($urandom_range(0, 2) == 0) : 1'b1;
                set_ch(i, 1'b1, d, l);
                exp_q[i].push_back('{data: d, last: l});
                in_pkt[i] = !l;
            end
        end
        tx_ready = ($urandom_range(0, 3) != 0);
        #1;
        xfer_prev = rx_valid & rx_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = '0;
        rx_last  = '0;
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        bit pending;

        fork
            monitor_loop();
        join_none

        rst       = 1'b1;
        rx_valid  = '0;
        rx_data   = '0;
        rx_last   = '0;
        tx_ready  = 1'b0;
        xfer_prev = '0;
        in_pkt    = '0;

        // Reset state.
        #1;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data",  64'(tx_data),  64'd0);
        check("rst_tx_last",  64'(tx_last),  64'd0);
        check("rst_tx_chan",  64'(tx_chan),  64'd0);
        check("rst_busy",     64'(o_busy),   64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_rx_ready", 64'(rx_ready), 64'd0);

        // Single beat on channel 2.
        @(negedge clk);
        tx_ready = 1'b1;
        set_ch(2, 1'b1, 32'hA5, 1'b1);
        #1;
        check("single_rx_ready", 64'(rx_ready), 64'b0100);
        @(negedge clk);
        rx_valid = '0;
        check("single_tx_valid", 64'(tx_valid), 64'd1);
        check("single_tx_data",  64'(tx_data),  64'hA5);
        check("single_tx_chan",  64'(tx_chan),  64'd2);
        check("single_tx_last",  64'(tx_last),  64'd1);
        @(negedge clk);
        check("single_drained", 64'(tx_valid), 64'd0);

        // Reset in the middle of an open packet with a held output beat.
        tx_ready = 1'b0;
        set_ch(1, 1'b1, 32'h55, 1'b0);
        #1;
        check("mid_rx_ready", 64'(rx_ready), 64'b0010);
        @(negedge clk);
        rx_valid = '0;
        check("mid_tx_valid", 64'(tx_valid), 64'd1);
        check("mid_busy",     64'(o_busy),   64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx_valid", 64'(tx_valid), 64'd0);
        check("arst_tx_data",  64'(tx_data),  64'd0);
        check("arst_tx_chan",  64'(tx_chan),  64'd0);
        check("arst_busy",     64'(o_busy),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rx_ready", 64'(rx_ready), 64'd0);

        // Fairness: all channels continuously valid with single-beat packets.
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 32'(i + 32'h20), 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_tx_valid", 64'(tx_valid), 64'd1);
            check("fair_tx_chan",  64'(tx_chan),  64'(i % NCH));
            check("fair_tx_data",  64'(tx_data),  64'((i % NCH) + 32'h20));
        end
        rx_valid = '0;
        @(negedge clk);

        // Packet lock: ch0 sends a 3-beat packet while ch1 waits.
        set_ch(0, 1'b1, 32'h10, 1'b0);
        set_ch(1, 1'b1, 32'h77, 1'b1);
        #1;
        check("lock_rx_ready0", 64'(rx_ready), 64'b0001);
        @(negedge clk);
        set_ch(0, 1'b1, 32'h11, 1'b0);
        check("lock_beat0", 64'(tx_data), 64'h10);
        check("lock_chan0", 64'(tx_chan), 64'd0);
        check("lock_busy0", 64'(o_busy),  64'd1);
        #1;
        check("lock_rx_ready1", 64'(rx_ready), 64'b0001);
        @(negedge clk);
        set_ch(0, 1'b1, 32'h12, 1'b1);
        check("lock_beat1", 64'(tx_data), 64'h11);
        check("lock_busy1", 64'(o_busy),  64'd1);
        #1;
        check("lock_rx_ready2", 64'(rx_ready), 64'b0001);
        @(negedge clk);
        rx_valid[0] = 1'b0;
        check("lock_beat2", 64'(tx_data), 64'h12);
        check("lock_last2", 64'(tx_last), 64'd1);
        check("lock_busy2", 64'(o_busy),  64'd0);
        #1;
        check("lock_rx_ready_ch1", 64'(rx_ready), 64'b0010);
        @(negedge clk);
        rx_valid[1] = 1'b0;
        check("lock_ch1_data", 64'(tx_data), 64'h77);
        check("lock_ch1_chan", 64'(tx_chan), 64'd1);
        @(negedge clk);

        // Backpressure on a channel-1 stream.
        set_ch(1, 1'b1, 32'hB0, 1'b1);
        @(negedge clk);
        check("bp_first", 64'(tx_data), 64'hB0);
        set_ch(1, 1'b1, 32'hB1, 1'b1);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rx_ready_low", 64'(rx_ready), 64'd0);
            @(negedge clk);
            check("bp_hold_valid", 64'(tx_valid), 64'd1);
            check("bp_hold_data",  64'(tx_data),  64'hB0);
            check("bp_hold_chan",  64'(tx_chan),  64'd1);
        end
        tx_ready = 1'b1;
        #1;
        check("bp_reload_ready", 64'(rx_ready), 64'b0010);
        @(negedge clk);
        rx_valid = '0;
        check("bp_next_valid", 64'(tx_valid), 64'd1);
        check("bp_next_data",  64'(tx_data),  64'hB1);
        @(negedge clk);
        check("bp_drained", 64'(tx_valid), 64'd0);

        // Randomized phase against the scoreboard and grant model.
        do_reset();
        model_ptr    = 0;
        model_locked = 1'b0;
        model_lock   = 0;
        out_in_pkt   = 1'b0;
        out_pkt_chan = 0;
        xfer_prev    = '0;
        in_pkt       = '0;
        rand_on      = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive_cycle(1'b1);
        end
        budget  = 0;
        pending = 1'b1;
        while (pending && budget < 2000) begin
            drive_cycle(1'b0);
            budget++;
            pending = tx_valid || (rx_valid != '0);
            for (int i = 0; i < NCH; i++) begin
                if (exp_q[i].size() != 0) pending = 1'b1;
            end
        end
        @(negedge clk);
        #3;
        rand_on = 1'b0;
        check("drain_complete", 64'(pending), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
